dm_sba_arbiter: RTL and testbench

//  Shares one system-bus master port between NrReq SBA-style requesters (e.g. dm_sba and a debug DMA).

---
 rtl/dm_sba_arbiter_pkg.sv | 30 +++
 rtl/dm_sba_owner_fifo.sv | 79 +++++++
 rtl/dm_sba_arbiter.sv | 158 +++++++++++++++
 tb/tb_dm_sba_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_sba_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : dm_sba_arbiter_pkg
//  Purpose : Shared types and helpers for the SBA bus arbiter slice.
//            - SbaBusWidth / SbaBeWidth : bus-width constants used by the
//              per-requester payload record.
//            - sba_req_t                : one requester's bus payload.
//            - idx_width()              : index width that never collapses
//                                         to zero bits.
//  Revision: 1.0  initial release
// ============================================================================
package dm_sba_arbiter_pkg;

   localparam int unsigned SbaBusWidth = 32;
   localparam int unsigned SbaBeWidth  = SbaBusWidth / 8;

   typedef struct packed {
      logic [SbaBusWidth-1:0] add;
      logic                   we;
      logic [SbaBusWidth-1:0] wdata;
      logic [SbaBeWidth-1:0]  be;
   } sba_req_t;

   // $clog2(1) is 0; a one-entry index still needs one bit to be declarable.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dm_sba_owner_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : dm_sba_owner_fifo
//  Purpose : In-order FIFO of requester indices, one entry per granted bus
//            access that has not yet received its response.
//  Ports   : clk_i, rst_i (async, active-high), flush_i (sync clear),
//            push_i/data_i (write index), pop_i/data_o (head index),
//            full_o, empty_o.
//            A push while full or a pop while empty is ignored.
//  Revision: 1.0  initial release
// ============================================================================
module dm_sba_owner_fifo
   import dm_sba_arbiter_pkg::*;
#(
   parameter int unsigned Depth = 2,
   parameter int unsigned DataW = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [DataW-1:0] data_i,
   input  logic             pop_i,
   output logic [DataW-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned     PtrW    = idx_width(Depth);
   localparam int unsigned     CntW    = $clog2(Depth + 1);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

   logic [DataW-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q;
   logic [PtrW-1:0]  rd_ptr_q;
   logic [CntW-1:0]  cnt_q;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign data_o  = mem_q[rd_ptr_q];

   // Pointers wrap explicitly so non-power-of-2 depths work.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
         end
         if (pop_ok) begin
            rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
         end
         if (push_ok && !pop_ok) begin
            cnt_q <= cnt_q + CntW'(1);
         end else if (!push_ok && pop_ok) begin
            cnt_q <= cnt_q - CntW'(1);
         end
      end
   end

   // Storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/dm_sba_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : dm_sba_arbiter
//  Purpose : Shares one system-bus master port between NrReq SBA-style
//            requesters. Round-robin selection with a lock that keeps an
//            ungranted bus request on the same source; an owner FIFO routes
//            each in-order response back to the requester that issued it.
//  Ports   : clk_i, rst_i (async, active-high)
//            req_i/add_i/we_i/wdata_i/be_i : packed per-requester requests
//            gnt_o, r_valid_o              : per-requester grant / response
//            r_rdata_o                     : response data (broadcast)
//            master_*                      : bus master port
//            spurious_rsp_o                : response with nothing outstanding
//  Revision: 1.0  initial release
// ============================================================================
module dm_sba_arbiter
   import dm_sba_arbiter_pkg::*;
#(
   parameter int unsigned NrReq          = 2,
   parameter int unsigned BusWidth       = SbaBusWidth,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NrReq-1:0]              req_i,
   input  logic [NrReq*BusWidth-1:0]     add_i,
   input  logic [NrReq-1:0]              we_i,
   input  logic [NrReq*BusWidth-1:0]     wdata_i,
   input  logic [NrReq*BusWidth/8-1:0]   be_i,
   output logic [NrReq-1:0]              gnt_o,
   output logic [NrReq-1:0]              r_valid_o,
   output logic [BusWidth-1:0]           r_rdata_o,
   output logic                          master_req_o,
   output logic [BusWidth-1:0]           master_add_o,
   output logic                          master_we_o,
   output logic [BusWidth-1:0]           master_wdata_o,
   output logic [BusWidth/8-1:0]         master_be_o,
   input  logic                          master_gnt_i,
   input  logic                          master_r_valid_i,
   input  logic [BusWidth-1:0]           master_r_rdata_i,
   output logic                          spurious_rsp_o
);

   localparam int unsigned     IdxW    = idx_width(NrReq);
   localparam int unsigned     BeW     = BusWidth / 8;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NrReq - 1);

   sba_req_t        req_pl [NrReq];
   sba_req_t        sel_pl;
   logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
   logic            lock_q, lock_d;
   logic [IdxW-1:0] lock_idx_q, lock_idx_d;
   logic [IdxW-1:0] arb_sel;
   logic [IdxW-1:0] sel;
   logic [IdxW-1:0] head;
   logic            fifo_full;
   logic            fifo_empty;
   logic            xfer;
   logic            rsp_hit;

   for (genvar g = 0; g < NrReq; g++) begin : g_unpack
      assign req_pl[g].add   = SbaBusWidth'(add_i[g*BusWidth +: BusWidth]);
      assign req_pl[g].we    = we_i[g];
      assign req_pl[g].wdata = SbaBusWidth'(wdata_i[g*BusWidth +: BusWidth]);
      assign req_pl[g].be    = SbaBeWidth'(be_i[g*BeW +: BeW]);
   end

   // First asserted request at or after rr_ptr_q, wrapping modulo NrReq.
   always_comb begin
      logic [IdxW:0] cand;
      logic          hit;
      cand    = '0;
      hit     = 1'b0;
      arb_sel = rr_ptr_q;
      for (int unsigned k = 0; k < NrReq; k++) begin
         cand = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
         if (cand >= (IdxW+1)'(NrReq)) begin
            cand = cand - (IdxW+1)'(NrReq);
         end
         if (!hit && req_i[cand[IdxW-1:0]]) begin
            hit     = 1'b1;
            arb_sel = cand[IdxW-1:0];
         end
      end
   end

   // A waiting bus request never changes source until it is granted.
   assign sel    = lock_q ? lock_idx_q : arb_sel;
   assign sel_pl = req_pl[sel];

   // A full owner FIFO blocks issue even if a response pops it this cycle.
   assign master_req_o   = ~rst_i & ~fifo_full & req_i[sel];
   assign xfer           = master_req_o & master_gnt_i;
   assign master_add_o   = rst_i ? '0   : BusWidth'(sel_pl.add);
   assign master_we_o    = rst_i ? 1'b0 : sel_pl.we;
   assign master_wdata_o = rst_i ? '0   : BusWidth'(sel_pl.wdata);
   assign master_be_o    = rst_i ? '0   : BeW'(sel_pl.be);

   always_comb begin
      gnt_o      = '0;
      gnt_o[sel] = xfer;
   end

   assign rsp_hit        = ~rst_i & master_r_valid_i & ~fifo_empty;
   assign spurious_rsp_o = ~rst_i & master_r_valid_i & fifo_empty;
   assign r_rdata_o      = rst_i ? '0 : master_r_rdata_i;

   always_comb begin
      r_valid_o       = '0;
      r_valid_o[head] = rsp_hit;
   end

   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (xfer) begin
         lock_d   = 1'b0;
         rr_ptr_d = (sel == LastIdx) ? '0 : sel + IdxW'(1);
      end else if (master_req_o) begin
         lock_d     = 1'b1;
         lock_idx_d = sel;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end

   dm_sba_owner_fifo #(
      .Depth (MaxOutstanding),
      .DataW (IdxW)
   ) u_owner_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (1'b0),
      .push_i  (xfer),
      .data_i  (sel),
      .pop_i   (rsp_hit),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Requesters must keep requesting while their access is parked in the lock.
   a_lock_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      lock_q |-> req_i[lock_idx_q]);

endmodule
`default_nettype wire

// File: tb/tb_dm_sba_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_dm_sba_arbiter
//  Purpose : Self-checking bench for dm_sba_arbiter (NrReq=2, 32-bit bus,
//            MaxOutstanding=2): vector table, directed multi-cycle
//            sequences, then randomized traffic against a queue-based model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_dm_sba_arbiter;

   localparam int N  = 2;
   localparam int BW = 32;
   localparam int MO = 2;

   logic              clk;
   logic              rst;
   logic [N-1:0]      req, we, gnt, rv;
   logic [N*BW-1:0]   add, wdata;
   logic [N*BW/8-1:0] be;
   logic [BW-1:0]     r_rdata, m_add, m_wdata, m_rdata;
   logic [BW/8-1:0]   m_be;
   logic              m_req, m_we, m_gnt, m_rv, spur;

   int n_tests = 0;
   int n_fail  = 0;

   dm_sba_arbiter #(
      .NrReq          (N),
      .BusWidth       (BW),
      .MaxOutstanding (MO)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .req_i            (req),
      .add_i            (add),
      .we_i             (we),
      .wdata_i          (wdata),
      .be_i             (be),
      .gnt_o            (gnt),
      .r_valid_o        (rv),
      .r_rdata_o        (r_rdata),
      .master_req_o     (m_req),
      .master_add_o     (m_add),
      .master_we_o      (m_we),
      .master_wdata_o   (m_wdata),
      .master_be_o      (m_be),
      .master_gnt_i     (m_gnt),
      .master_r_valid_i (m_rv),
      .master_r_rdata_i (m_rdata),
      .spurious_rsp_o   (spur)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled
   // 2 units later, well clear of either clock edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic set_pl(input int i, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] b);
      add[i*BW +: BW]     = a;
      we[i]               = w;
      wdata[i*BW +: BW]   = d;
      be[i*BW/8 +: BW/8]  = b;
   endtask

   task automatic idle();
      req     = '0;
      m_gnt   = 1'b0;
      m_rv    = 1'b0;
      m_rdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // ---------------------------------------------------------------- table
   typedef struct {
      logic [1:0]  req;
      logic        gnt;
      logic        rv;
      logic        e_mreq;
      logic [1:0]  e_gnt;
      logic [1:0]  e_rv;
      logic        e_spur;
      logic [31:0] e_add;
   } vec_t;

   vec_t tbl[14];

   function automatic vec_t mk(input logic [1:0] r, input logic g, input logic v,
                               input logic em, input logic [1:0] eg,
                               input logic [1:0] ev, input logic es,
                               input logic [31:0] ea);
      vec_t t;
      t.req = r; t.gnt = g; t.rv = v; t.e_mreq = em;
      t.e_gnt = eg; t.e_rv = ev; t.e_spur = es; t.e_add = ea;
      return t;
   endfunction

   // ------------------------------------------------------- reference model
   int          md_rr;
   bit          md_lock;
   int          md_lock_idx;
   int          md_owner[$];
   bit          pend[N];
   logic [31:0] pa[N], pd[N];
   logic        pw[N];
   logic [3:0]  pb[N];

   task automatic rand_cycle();
      int   s;
      bit   found;
      bit   e_mreq, e_xfer, e_spur;
      logic [N-1:0] e_gnt, e_rv;
      for (int i = 0; i < N; i++) begin
         if (!pend[i] && $urandom_range(0, 2) == 0) begin
            pend[i] = 1'b1;
            pa[i]   = $urandom;
            pw[i]   = 1'($urandom_range(0, 1));
            pd[i]   = $urandom;
            pb[i]   = 4'($urandom_range(0, 15));
         end
         req[i] = pend[i];
         set_pl(i, pa[i], pw[i], pd[i], pb[i]);
      end
      m_gnt   = ($urandom_range(0, 3) != 0);
      m_rv    = (md_owner.size() > 0) ? 1'($urandom_range(0, 1))
                                      : ($urandom_range(0, 9) == 0);
      m_rdata = $urandom;
      settle();

      if (md_lock) begin
         s = md_lock_idx;
      end else begin
         s     = md_rr;
         found = 1'b0;
         for (int k = 0; k < N; k++) begin
            if (!found && req[(md_rr + k) % N]) begin
               found = 1'b1;
               s     = (md_rr + k) % N;
            end
         end
      end
      e_mreq = req[s] && (md_owner.size() < MO);
      e_xfer = e_mreq && m_gnt;
      e_gnt  = '0;
      if (e_xfer) e_gnt[s] = 1'b1;
      e_rv   = '0;
      if (m_rv && md_owner.size() > 0) e_rv[md_owner[0]] = 1'b1;
      e_spur = m_rv && (md_owner.size() == 0);

      chk("rnd_master_req", m_req, e_mreq);
      chk("rnd_gnt", gnt, e_gnt);
      chk("rnd_r_valid", rv, e_rv);
      chk("rnd_spurious", spur, e_spur);
      chk("rnd_rdata", r_rdata, m_rdata);
      if (e_mreq) begin
         chk("rnd_master_add", m_add, pa[s]);
         chk("rnd_master_we", m_we, pw[s]);
         chk("rnd_master_wdata", m_wdata, pd[s]);
         chk("rnd_master_be", m_be, pb[s]);
      end

      if (m_rv && md_owner.size() > 0) void'(md_owner.pop_front());
      if (e_xfer) begin
         md_owner.push_back(s);
         md_rr   = (s + 1) % N;
         md_lock = 1'b0;
         pend[s] = 1'b0;
      end else if (e_mreq) begin
         md_lock     = 1'b1;
         md_lock_idx = s;
      end
      tick();
   endtask

   // ------------------------------------------------------------ sequence
   initial begin
      rst = 1'b1;
      idle();
      we = '0; add = '0; wdata = '0; be = '0;
      do_reset();

      // Reset-state outputs
      settle();
      chk("reset_master_req", m_req, 1'b0);
      chk("reset_gnt", gnt, 2'b00);
      chk("reset_r_valid", rv, 2'b00);
      chk("reset_spurious", spur, 1'b0);

      // Table: spurious pulse, rotation, full-FIFO blocking, drain.
      tbl[0]  = mk(2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 32'h0);
      tbl[1]  = mk(2'b00, 0, 1, 0, 2'b00, 2'b00, 1, 32'h0);
      tbl[2]  = mk(2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 32'h0);
      tbl[3]  = mk(2'b11, 1, 0, 1, 2'b01, 2'b00, 0, 32'h1000);
      tbl[4]  = mk(2'b11, 1, 1, 1, 2'b10, 2'b01, 0, 32'h2000);
      tbl[5]  = mk(2'b11, 1, 1, 1, 2'b01, 2'b10, 0, 32'h1000);
      tbl[6]  = mk(2'b11, 1, 1, 1, 2'b10, 2'b01, 0, 32'h2000);
      tbl[7]  = mk(2'b11, 1, 0, 1, 2'b01, 2'b00, 0, 32'h1000);
      tbl[8]  = mk(2'b11, 1, 0, 0, 2'b00, 2'b00, 0, 32'h0);
      tbl[9]  = mk(2'b11, 1, 1, 0, 2'b00, 2'b10, 0, 32'h0);
      tbl[10] = mk(2'b11, 1, 0, 1, 2'b10, 2'b00, 0, 32'h2000);
      tbl[11] = mk(2'b00, 0, 1, 0, 2'b00, 2'b01, 0, 32'h0);
      tbl[12] = mk(2'b00, 0, 1, 0, 2'b00, 2'b10, 0, 32'h0);
      tbl[13] = mk(2'b00, 0, 1, 0, 2'b00, 2'b00, 1, 32'h0);

      set_pl(0, 32'h1000, 1'b0, 32'h0, 4'hF);
      set_pl(1, 32'h2000, 1'b1, 32'h5A5A5A5A, 4'h3);
      for (int r = 0; r < 14; r++) begin
         req     = tbl[r].req;
         m_gnt   = tbl[r].gnt;
         m_rv    = tbl[r].rv;
         m_rdata = 32'h11110000 + 32'(r);
         settle();
         chk($sformatf("tbl%0d_master_req", r), m_req, tbl[r].e_mreq);
         chk($sformatf("tbl%0d_gnt", r), gnt, tbl[r].e_gnt);
         chk($sformatf("tbl%0d_r_valid", r), rv, tbl[r].e_rv);
         chk($sformatf("tbl%0d_spurious", r), spur, tbl[r].e_spur);
         chk($sformatf("tbl%0d_rdata", r), r_rdata, 32'h11110000 + 32'(r));
         if (tbl[r].e_mreq) chk($sformatf("tbl%0d_master_add", r), m_add, tbl[r].e_add);
         tick();
      end
      idle();

      // Lock: req0 waits ungranted while req1 (favoured by the pointer) rises.
      do_reset();
      set_pl(0, 32'hA0, 1'b0, 32'h0, 4'hF);
      set_pl(1, 32'hB0, 1'b1, 32'h0, 4'hF);
      req = 2'b01; m_gnt = 1'b1;
      settle(); chk("lock_pre_gnt", gnt, 2'b01);
      tick();
      req = 2'b01; m_gnt = 1'b0; m_rv = 1'b1;
      settle();
      chk("lock_c0_mreq", m_req, 1'b1);
      chk("lock_c0_add", m_add, 32'hA0);
      chk("lock_c0_gnt", gnt, 2'b00);
      chk("lock_c0_rv", rv, 2'b01);
      tick();
      m_rv = 1'b0; req = 2'b11;
      for (int c = 1; c <= 2; c++) begin
         settle();
         chk($sformatf("lock_c%0d_add", c), m_add, 32'hA0);
         chk($sformatf("lock_c%0d_gnt", c), gnt, 2'b00);
         tick();
      end
      m_gnt = 1'b1;
      settle();
      chk("lock_c3_gnt", gnt, 2'b01);
      chk("lock_c3_add", m_add, 32'hA0);
      tick();
      req = 2'b10;
      settle();
      chk("lock_c4_gnt", gnt, 2'b10);
      chk("lock_c4_add", m_add, 32'hB0);
      tick();
      req = 2'b00; m_gnt = 1'b0; m_rv = 1'b1;
      settle(); chk("lock_rsp0", rv, 2'b01);
      tick();
      settle(); chk("lock_rsp1", rv, 2'b10);
      tick();
      idle();

      // Routing: write from req1, read from req0, responses return in order.
      set_pl(1, 32'h100, 1'b1, 32'h12345678, 4'hF);
      req = 2'b10; m_gnt = 1'b1;
      settle();
      chk("route_wr_gnt", gnt, 2'b10);
      chk("route_wr_add", m_add, 32'h100);
      chk("route_wr_we", m_we, 1'b1);
      chk("route_wr_wdata", m_wdata, 32'h12345678);
      chk("route_wr_be", m_be, 4'hF);
      tick();
      set_pl(0, 32'h104, 1'b0, 32'h0, 4'hF);
      req = 2'b01; m_rv = 1'b1; m_rdata = 32'h0;
      settle();
      chk("route_rd_gnt", gnt, 2'b01);
      chk("route_rd_add", m_add, 32'h104);
      chk("route_rd_we", m_we, 1'b0);
      chk("route_rsp0_rv", rv, 2'b10);
      chk("route_rsp0_rdata", r_rdata, 32'h0);
      tick();
      req = 2'b00; m_gnt = 1'b0; m_rdata = 32'hCAFEF00D;
      settle();
      chk("route_rsp1_rv", rv, 2'b01);
      chk("route_rsp1_rdata", r_rdata, 32'hCAFEF00D);
      chk("route_rsp1_spur", spur, 1'b0);
      tick();
      idle();

      // Reset mid-operation with one access outstanding and the lock set.
      do_reset();
      set_pl(0, 32'hA0, 1'b0, 32'h0, 4'hF);
      set_pl(1, 32'hB0, 1'b1, 32'hFFFFFFFF, 4'hF);
      req = 2'b11; m_gnt = 1'b1;
      settle(); chk("rst_pre_gnt0", gnt, 2'b01);
      tick();
      m_gnt = 1'b0;
      settle();
      chk("rst_pre_lock_mreq", m_req, 1'b1);
      chk("rst_pre_lock_add", m_add, 32'hB0);
      tick();
      rst = 1'b1; m_gnt = 1'b1; m_rv = 1'b1; m_rdata = 32'hDEADBEEF;
      settle();
      chk("rst_mreq", m_req, 1'b0);
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_rv", rv, 2'b00);
      chk("rst_spur", spur, 1'b0);
      chk("rst_add", m_add, 32'h0);
      chk("rst_we", m_we, 1'b0);
      chk("rst_wdata", m_wdata, 32'h0);
      chk("rst_be", m_be, 4'h0);
      chk("rst_rdata", r_rdata, 32'h0);
      tick();
      settle(); chk("rst_hold_mreq", m_req, 1'b0);
      tick();
      rst = 1'b0; m_gnt = 1'b0; m_rv = 1'b1; m_rdata = 32'h55;
      settle();
      chk("post_rst_spur", spur, 1'b1);
      chk("post_rst_rv", rv, 2'b00);
      chk("post_rst_mreq", m_req, 1'b1);
      chk("post_rst_add", m_add, 32'hA0);
      tick();
      m_rv = 1'b0; m_gnt = 1'b1;
      settle(); chk("post_rst_gnt", gnt, 2'b01);
      tick();
      req = 2'b00; m_gnt = 1'b0; m_rv = 1'b1;
      settle();
      chk("post_rst_rsp", rv, 2'b01);
      chk("post_rst_rsp_spur", spur, 1'b0);
      tick();
      idle();

      // Randomized traffic against the queue model.
      do_reset();
      md_rr = 0; md_lock = 1'b0; md_lock_idx = 0;
      md_owner.delete();
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      for (int c = 0; c < 400; c++) rand_cycle();
      idle();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
